// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: serial shifter, or a single-cycle barrel shifter when SHIFT_FAST_EN is defined.
// Issues one operation at a time to an external combinational ALU and holds the result until writeback takes it.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_ctrl,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_l,
    output logic [31:0] alu_r,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] OP_SRA = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8;
    localparam logic [4:0] OP_SLL = 5'd9;

    state_t      state_q, state_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic        accept;

    function automatic logic is_shift(input logic [4:0] c);
        return (c == OP_SRA) || (c == OP_SRL) || (c == OP_SLL);
    endfunction

    // One serial step; a_q doubles as the shift accumulator.
    function automatic logic [31:0] shift_one(input logic [4:0] c, input logic [31:0] v);
        logic [31:0] r;
        case (c)
            OP_SRA:  r = {v[31], v[31:1]};
            OP_SRL:  r = {1'b0, v[31:1]};
            OP_SLL:  r = {v[30:0], 1'b0};
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_FAST_EN
    function automatic logic [31:0] barrel(input logic [4:0] c, input logic [31:0] v,
                                           input logic [4:0] sh);
        logic signed [31:0] sv;
        logic [31:0]        r;
        sv = v;
        case (c)
            OP_SRA:  r = sv >>> sh;
            OP_SRL:  r = v >> sh;
            OP_SLL:  r = v << sh;
            default: r = v;
        endcase
        return r;
    endfunction
`endif

    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_rd    = rd_q;
    assign alu_l     = (state_q == EXEC) ? a_q    : 32'd0;
    assign alu_r     = (state_q == EXEC) ? b_q    : 32'd0;
    assign alu_ctrl  = (state_q == EXEC) ? ctrl_q : 5'd0;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctrl_d = in_ctrl;
                    a_d    = in_a;
                    b_d    = in_b;
                    rd_d   = in_rd;
                    cnt_d  = in_b[4:0];
`ifdef SHIFT_FAST_EN
                    state_d = EXEC;
`else
                    state_d = is_shift(in_ctrl) ? SHIFT : EXEC;
`endif
                end
            end
            EXEC: begin
`ifdef SHIFT_FAST_EN
                out_data_d = is_shift(ctrl_q) ? barrel(ctrl_q, a_q, b_q[4:0]) : alu_result;
`else
                out_data_d = alu_result;
`endif
                state_d = DONE;
            end
            SHIFT: begin
                if (cnt_q != 5'd0) begin
                    a_d   = shift_one(ctrl_q, a_q);
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    out_data_d = a_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Leaving DONE always passes through IDLE before the next accept.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctrl_q     <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 5'd0;
            out_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: none; the data width is fixed at 32 bits and the operation code width at 5 bits.
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port `in_valid`: input, 1 bit, decode presents an operation.
REQ-005 SHALL have port `in_ready`: output, 1 bit, stage accepts an operation this cycle.
REQ-006 SHALL have port `in_ctrl`: input, 5 bits, ALU operation code; 0-17 follow the ALU encoding, 7/8/9 are handled locally.
REQ-007 SHALL have ports `in_a` and `in_b`: inputs, 32 bits each, left and right operands.
REQ-008 SHALL have port `in_rd`: input, 5 bits, destination register tag.
REQ-009 SHALL have ports `alu_l`, `alu_r` (output, 32 bits each) and `alu_ctrl` (output, 5 bits): drive the combinational ALU.
REQ-010 SHALL have port `alu_result`: input, 32 bits, combinational ALU result.
REQ-011 SHALL have ports `out_valid` (output, 1 bit) and `out_ready` (input, 1 bit): result handshake toward writeback.
REQ-012 SHALL have ports `out_data` (output, 32 bits) and `out_rd` (output, 5 bits): result value and its tag.
REQ-013 SHALL have port `busy`: output, 1 bit, high in any state other than IDLE.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, EXEC, SHIFT, DONE.
REQ-015 SHALL assert `in_ready` only in IDLE; a transfer occurs on a rising edge with `in_valid` and `in_ready` both high.
REQ-016 SHALL, on a transfer, register `in_ctrl`, `in_a`, `in_b` and `in_rd`.
REQ-017 SHALL, on a transfer, go to EXEC for codes other than 7/8/9.
REQ-018 SHALL, on a transfer of code 7/8/9, go to SHIFT with count = `in_b[4:0]` and accumulator = `in_a`.
REQ-019 SHALL, in EXEC, drive `alu_l`/`alu_r`/`alu_ctrl` from the registered operands and code.
REQ-020 SHALL, at the end of EXEC, capture `alu_result` into `out_data` and go to DONE; the ALU latency is exactly one EXEC cycle.
REQ-021 SHALL drive `alu_l`, `alu_r` and `alu_ctrl` to 0 outside EXEC.
REQ-022 SHALL, in SHIFT with count nonzero, shift the accumulator by one bit per cycle and decrement count.
REQ-023 SHALL use these shifts: code 7 arithmetic right (replicate bit 31), code 8 logical right, code 9 left (zero fill).
REQ-024 SHALL, in SHIFT with count 0, copy the accumulator to `out_data` and go to DONE; shift amount 0 costs one SHIFT cycle and returns `in_a`.
REQ-025 SHALL ignore `in_b[31:5]` for shifts.
REQ-026 SHALL hold `out_valid` high in DONE.
REQ-027 SHALL keep `out_data` and `out_rd` stable until `out_ready` is sampled high; DONE then returns to IDLE.
REQ-028 SHALL require one IDLE cycle between operations (no back-to-back accept in the DONE exit cycle).
REQ-029 SHALL forward codes 10, 11 and 18-31 unchanged to the ALU; the result is whatever the ALU returns (0 for undefined codes).
REQ-030 SHALL ignore `in_valid` while not in IDLE; inputs change freely without effect.

Reset
REQ-031 SHALL, while `rst_n` is low, force state to IDLE and all registered outputs to 0.
REQ-032 SHALL, while `rst_n` is low, hold `out_valid` at 0 and `busy` at 0.
REQ-033 SHALL drive `in_ready` to 1 once `rst_n` deasserts.
REQ-034 SHALL discard any in-flight operation on a reset in EXEC, SHIFT or DONE, with no output produced.
REQ-035 SHALL register the deassertion of `rst_n` through the flops and process no transfer in the same edge.

Configuration
REQ-036 SHALL, when macro SHIFT_FAST_EN is defined, perform codes 7/8/9 with a single-cycle barrel shifter in EXEC (same latency as ALU ops) and never enter SHIFT.
REQ-037 SHALL, when SHIFT_FAST_EN is undefined, use the serial shifter of REQ-018, REQ-022, REQ-023 and REQ-024.

Verification
REQ-038 SHALL cover: ADD code 0, a=5, b=7, rd=3 -> `out_valid` 2 cycles after the transfer, `out_data`=12, `out_rd`=3.
REQ-039 SHALL cover: code 7, a=0x80000010, b=4 -> `out_data`=0xF8000001; serial: 5 SHIFT cycles; fast: 1 EXEC cycle.
REQ-040 SHALL cover: code 9, a=1, b=0x25 (shamt 5) -> `out_data`=0x20; and code 8, a=0xFFFFFFFF, b=0 -> `out_data`=0xFFFFFFFF.
REQ-041 SHALL cover: `out_ready` held low 10 cycles in DONE -> `out_valid` and `out_data` stable, `in_ready`=0, new `in_valid` pulses ignored.
REQ-042 SHALL cover: `rst_n` pulsed low mid-SHIFT (b=31) -> all outputs 0 immediately, `in_ready`=1 after release, no stale result.
REQ-043 SHALL cover: code 12, a=b=0xDEADBEEF -> `alu_ctrl`=12 during EXEC only, `out_data`=1.
